// File: rtl/button_conditioner_if.sv
// Button bus between the raw launchpad inputs and the conditioned outputs
// consumed by the event animation stages. One bit per button channel.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;      // asynchronous raw inputs, 1 = pressed
  logic [N_BTN-1:0] btn_level;    // debounced level
  logic [N_BTN-1:0] btn_press;    // one-cycle pulse on debounced 0->1
  logic [N_BTN-1:0] btn_release;  // one-cycle pulse on debounced 1->0
  logic [N_BTN-1:0] btn_repeat;   // one-cycle auto-repeat pulses while held

  // Driver side: produces raw buttons, observes conditioned outputs
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  // Conditioner side: consumes raw buttons, produces conditioned outputs
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel button front-end: per channel a 2-flop synchronizer,
// consecutive-sample debounce filter, press/release pulse generation and an
// auto-repeat pulse generator while held. Channels share no state.
module button_conditioner #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 8,
  parameter int HOLD_CYCLES   = 32,
  parameter int REPEAT_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  button_conditioner_if.slave       bus
);

  // Terminal counter values; all counters clear here and so never wrap.
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_t;

  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] press_o;
  logic [N_BTN-1:0] release_o;
  logic [N_BTN-1:0] repeat_o;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi = gi + 1) begin : g_chan
      // Synchronizer
      logic             s1_q;
      logic             s2_q;
      // Debounce filter
      logic             level_q, level_d;
      logic [CNT_W-1:0] dcnt_q, dcnt_d;
      logic             accept;
      // Edge pulses
      logic             press_q, press_d;
      logic             release_q, release_d;
      // Auto-repeat
      rpt_state_t       state_q, state_d;
      logic [CNT_W-1:0] rcnt_q, rcnt_d;
      logic             repeat_q, repeat_d;

      // Debounce: a new level is accepted only after DB_CYCLES consecutive
      // synchronized samples that differ from the current level; any sample
      // matching the level restarts the count.
      always_comb begin
        level_d = level_q;
        dcnt_d  = dcnt_q;
        accept  = 1'b0;
        if (s2_q == level_q) begin
          dcnt_d = '0;
        end else if (dcnt_q == DB_LAST) begin
          level_d = s2_q;
          dcnt_d  = '0;
          accept  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
        // Pulses are registered alongside the level so they coincide with
        // the first cycle the new level is visible.
        press_d   = accept & s2_q;
        release_d = accept & ~s2_q;
      end

      // Repeat FSM next-state: HOLD times the initial delay after a press,
      // RPT times the spacing between repeats. A release always wins over a
      // coinciding counter expiry, so no repeat is emitted with level low.
      always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        case (state_q)
          ST_IDLE: begin
            rcnt_d = '0;
            if (press_d) begin
              state_d = ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (release_d) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == HOLD_LAST) begin
              state_d  = ST_RPT;
              rcnt_d   = '0;
              repeat_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          ST_RPT: begin
            if (release_d) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == REPEAT_LAST) begin
              rcnt_d   = '0;
              repeat_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end

      // Channel state registers; reset clears everything, so a reset during
      // a hold yields no release pulse and a still-pressed button must pass
      // the full sync + debounce path again.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q      <= 1'b0;
          s2_q      <= 1'b0;
          level_q   <= 1'b0;
          dcnt_q    <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          state_q   <= ST_IDLE;
          rcnt_q    <= '0;
          repeat_q  <= 1'b0;
        end else begin
          s1_q      <= bus.btn_raw[gi];
          s2_q      <= s1_q;
          level_q   <= level_d;
          dcnt_q    <= dcnt_d;
          press_q   <= press_d;
          release_q <= release_d;
          state_q   <= state_d;
          rcnt_q    <= rcnt_d;
          repeat_q  <= repeat_d;
        end
      end

      assign level_o[gi]   = level_q;
      assign press_o[gi]   = press_q;
      assign release_o[gi] = release_q;
      assign repeat_o[gi]  = repeat_q;
    end
  endgenerate

  assign bus.btn_level   = level_o;
  assign bus.btn_press   = press_o;
  assign bus.btn_release = release_o;
  assign bus.btn_repeat  = repeat_o;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, HOLD_CYCLES=10,
// REPEAT_CYCLES=3. Outputs are sampled 1 time unit after each rising edge.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(4)) bus ();

  button_conditioner #(
    .N_BTN(4),
    .DB_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One line per sampled cycle, then the four output vectors compared.
  task automatic check_outs(input string tag, input logic [3:0] lv, input logic [3:0] pr,
                            input logic [3:0] rl, input logic [3:0] rp);
    $display("%s: level=%b press=%b release=%b repeat=%b", tag,
             bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat);
    check({tag, " level"},   32'(bus.btn_level),   32'(lv));
    check({tag, " press"},   32'(bus.btn_press),   32'(pr));
    check({tag, " release"}, 32'(bus.btn_release), 32'(rl));
    check({tag, " repeat"},  32'(bus.btn_repeat),  32'(rp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_outs("reset1", 4'b0, 4'b0, 4'b0, 4'b0);
    tick();
    check_outs("reset2", 4'b0, 4'b0, 4'b0, 4'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic rp;
    logic [3:0] lv, rl, rpv;
    bus.btn_raw = 4'b0;

    // Reset state
    do_reset();

    // 1. Clean press on channel 0: level/press visible after E5
    bus.btn_raw = 4'b0001;
    for (int e = 0; e < 5; e++) begin
      tick();
      check_outs($sformatf("press_lat e%0d", e), 4'b0, 4'b0, 4'b0, 4'b0);
    end
    tick();
    check_outs("press P", 4'b0001, 4'b0001, 4'b0, 4'b0);

    // 2+3. Hold: repeats at P+10, +13, ...; raw dropped in cycle P+31 so the
    // release lands in P+37, which is also a repeat expiry cycle.
    for (int k = 1; k <= 42; k++) begin
      tick();
      rp = (k >= 10) && (((k - 10) % 3) == 0) && (k < 37);
      lv = (k < 37) ? 4'b0001 : 4'b0000;
      rl = (k == 37) ? 4'b0001 : 4'b0000;
      check_outs($sformatf("hold P+%0d", k), lv, 4'b0, rl, {3'b0, rp});
      if (k == 31) bus.btn_raw = 4'b0000;
    end

    // 4. Glitch on channel 1: 3 high, 1 low, 3 high, low
    for (int k = 0; k < 22; k++) begin
      if (k < 3 || (k >= 4 && k < 7)) bus.btn_raw = 4'b0010;
      else bus.btn_raw = 4'b0000;
      tick();
      check_outs($sformatf("glitch c%0d", k), 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // 5. Channel 2 held into RPT, then reset for 2 cycles with raw high
    bus.btn_raw = 4'b0100;
    for (int e = 0; e < 5; e++) tick();
    tick();
    check_outs("ch2 press", 4'b0100, 4'b0100, 4'b0, 4'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      rp = (k == 10);
      check_outs($sformatf("ch2 hold P+%0d", k), 4'b0100, 4'b0, 4'b0, {1'b0, rp, 2'b0});
    end
    do_reset();
    for (int e = 0; e < 5; e++) begin
      tick();
      check_outs($sformatf("post_rst e%0d", e), 4'b0, 4'b0, 4'b0, 4'b0);
    end
    tick();
    check_outs("post_rst press", 4'b0100, 4'b0100, 4'b0, 4'b0);

    // 6. Simultaneous press on all channels, release only channel 3
    bus.btn_raw = 4'b0000;
    do_reset();
    bus.btn_raw = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      tick();
      check_outs($sformatf("all_lat e%0d", e), 4'b0, 4'b0, 4'b0, 4'b0);
    end
    tick();
    check_outs("all press", 4'b1111, 4'b1111, 4'b0, 4'b0);
    for (int k = 1; k <= 26; k++) begin
      tick();
      rp  = (k >= 10) && (((k - 10) % 3) == 0);
      lv  = (k < 20) ? 4'b1111 : 4'b0111;
      rl  = (k == 20) ? 4'b1000 : 4'b0000;
      rpv = {rp & (k < 20), rp, rp, rp};
      check_outs($sformatf("all P+%0d", k), lv, 4'b0, rl, rpv);
      if (k == 14) bus.btn_raw = 4'b0111;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
